// File: rtl/tile_load_exec_sequencer_if.sv
// Descriptor, memory-port and store-engine signals of the tile sequencer.
// master = sequencer side, slave = config buffer / memory / store engine.
interface tile_load_exec_sequencer_if #(
  parameter int AW = 32,
  parameter int SW = 5
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_mode;
  logic          cfg_store;
  logic [AW-1:0] cfg_b_addr;
  logic [AW-1:0] cfg_a_addr;
  logic [AW-1:0] cfg_b_stride;
  logic [AW-1:0] cfg_a_stride;
  logic [SW-1:0] cfg_msize;
  logic [SW-1:0] cfg_ksize;
  logic [SW-1:0] cfg_nsize;
  logic          ready_for_hi;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [SW-1:0] req_len;
  logic          req_we;
  logic          st_start;
  logic          st_req_valid;
  logic [AW-1:0] st_req_addr;
  logic [SW-1:0] st_req_len;
  logic          st_req_we;
  logic          st_done;
  logic          wfetch;
  logic          if_en;
  logic          prefetch_start;
  logic          prefetch_done;
  logic          cfg_err;
  logic          busy;

  modport master (
    input  cfg_valid, cfg_mode, cfg_store,
    input  cfg_b_addr, cfg_a_addr,
    input  cfg_b_stride, cfg_a_stride,
    input  cfg_msize, cfg_ksize, cfg_nsize,
    input  ready_for_hi, req_ready,
    input  st_req_valid, st_req_addr,
    input  st_req_len, st_req_we, st_done,
    output cfg_ready, req_valid, req_addr,
    output req_len, req_we, st_start,
    output wfetch, if_en,
    output prefetch_start, prefetch_done,
    output cfg_err, busy
  );

  modport slave (
    output cfg_valid, cfg_mode, cfg_store,
    output cfg_b_addr, cfg_a_addr,
    output cfg_b_stride, cfg_a_stride,
    output cfg_msize, cfg_ksize, cfg_nsize,
    output ready_for_hi, req_ready,
    output st_req_valid, st_req_addr,
    output st_req_len, st_req_we, st_done,
    input  cfg_ready, req_valid, req_addr,
    input  req_len, req_we, st_start,
    input  wfetch, if_en,
    input  prefetch_start, prefetch_done,
    input  cfg_err, busy
  );
endinterface

// File: rtl/tile_load_exec_sequencer.sv
// Load/execute sequencer: pops tile descriptors, prefetches B rows,
// streams A rows, optionally lends the memory port to the store engine.
module tile_load_exec_sequencer #(
  parameter int AW = 32,
  parameter int SW = 5
) (
  input  logic clk,
  input  logic rst,
  tile_load_exec_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    COMPUTE,
    STORE,
    CHECK_NEXT
  } state_t;

  localparam logic [SW-1:0] ONE = SW'(1);

  state_t        state, state_nx;
  logic [SW-1:0] cnt, cnt_nx;
  logic [AW-1:0] addr, addr_nx;
  logic          take;

  logic [1:0]    mode_q;
  logic          store_q;
  logic [AW-1:0] a_addr_q;
  logic [AW-1:0] b_stride_q;
  logic [AW-1:0] a_stride_q;
  logic [SW-1:0] msize_q;
  logic [SW-1:0] ksize_q;
  logic [SW-1:0] nsize_q;

  always_comb begin
    state_nx           = state;
    cnt_nx             = cnt;
    addr_nx            = addr;
    take               = 1'b0;
    bus.cfg_ready      = 1'b0;
    bus.cfg_err        = 1'b0;
    bus.req_valid      = 1'b0;
    bus.req_addr       = '0;
    bus.req_len        = '0;
    bus.req_we         = 1'b0;
    bus.st_start       = 1'b0;
    bus.wfetch         = 1'b0;
    bus.if_en          = 1'b0;
    bus.prefetch_start = 1'b0;
    bus.prefetch_done  = 1'b0;
    unique case (state)
      IDLE: take = bus.cfg_valid;
      PREFETCH: begin
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = nsize_q;
        if (bus.req_ready) begin
          bus.wfetch = 1'b1;
          cnt_nx     = cnt + ONE;
          addr_nx    = addr - b_stride_q;
          if (cnt == ksize_q - ONE) begin
            bus.prefetch_done = 1'b1;
            cnt_nx            = '0;
            addr_nx           = a_addr_q;
            state_nx          = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = ksize_q;
        if (bus.req_ready) begin
          bus.if_en = 1'b1;
          cnt_nx    = cnt + ONE;
          addr_nx   = addr + a_stride_q;
          if (cnt == msize_q - ONE) begin
            cnt_nx = '0;
            if (store_q) begin
              bus.st_start = 1'b1;
              state_nx     = STORE;
            end else begin
              state_nx = CHECK_NEXT;
            end
          end
        end
      end
      STORE: begin
        bus.req_valid = bus.st_req_valid;
        bus.req_addr  = bus.st_req_addr;
        bus.req_len   = bus.st_req_len;
        bus.req_we    = bus.st_req_we;
        if (bus.st_done) state_nx = CHECK_NEXT;
      end
      CHECK_NEXT: begin
        // HW/IW tiles wait for the downstream consumer
        if (!bus.cfg_valid) state_nx = IDLE;
        else if (!mode_q[1] || bus.ready_for_hi) take = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (take) begin
      bus.cfg_ready = 1'b1;
      if (bus.cfg_ksize == '0 || bus.cfg_msize == '0) begin
        bus.cfg_err = 1'b1;
        state_nx    = IDLE;
      end else begin
        bus.prefetch_start = 1'b1;
        cnt_nx             = '0;
        addr_nx            = bus.cfg_b_addr;
        state_nx           = PREFETCH;
      end
    end
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      addr  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      addr  <= addr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= '0;
      store_q    <= 1'b0;
      a_addr_q   <= '0;
      b_stride_q <= '0;
      a_stride_q <= '0;
      msize_q    <= '0;
      ksize_q    <= '0;
      nsize_q    <= '0;
    end else if (take) begin
      mode_q     <= bus.cfg_mode;
      store_q    <= bus.cfg_store;
      a_addr_q   <= bus.cfg_a_addr;
      b_stride_q <= bus.cfg_b_stride;
      a_stride_q <= bus.cfg_a_stride;
      msize_q    <= bus.cfg_msize;
      ksize_q    <= bus.cfg_ksize;
      nsize_q    <= bus.cfg_nsize;
    end
  end

endmodule

// File: tb/tb_tile_load_exec_sequencer.sv
// Scoreboard bench: descriptors expand into expected memory requests
// at issue time; a negedge monitor pops and compares every handshake.
module tb_tile_load_exec_sequencer;
  localparam int AW = 32;
  localparam int SW = 5;

  typedef struct {
    logic [1:0]  mode;
    logic        store;
    logic [31:0] b_addr;
    logic [31:0] a_addr;
    logic [31:0] b_stride;
    logic [31:0] a_stride;
    logic [4:0]  m;
    logic [4:0]  k;
    logic [4:0]  n;
  } desc_t;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  len;
    logic        we;
    int          kind;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_load_exec_sequencer_if #(.AW(AW), .SW(SW)) bus ();
  tile_load_exec_sequencer #(.AW(AW), .SW(SW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  desc_t cbuf[$];
  req_t  exp_req[$];
  bit    exp_err[$];

  int total = 0;
  int bad = 0;
  int n_wf = 0, n_if = 0, n_ps = 0, n_pd = 0, n_st = 0, n_err = 0;
  int exp_ps = 0, exp_pd = 0, exp_st = 0;
  int st_issue = 0, st_eng = 0;
  int rr_mode = 0, rr_phase = 0;
  int rfh_mode = 0;
  bit rfh_force = 1'b1;
  bit pop_pend = 1'b0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h need %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] st_base(int i);
    return 32'h3000 + 32'(i) * 32'h100;
  endfunction

  task automatic push_desc(desc_t d);
    req_t e;
    bit err;
    err = (d.k == 0) || (d.m == 0);
    exp_err.push_back(err);
    if (!err) begin
      exp_ps++;
      exp_pd++;
      for (int r = 0; r < int'(d.k); r++) begin
        e.addr = d.b_addr - 32'(r) * d.b_stride;
        e.len = d.n; e.we = 1'b0; e.kind = 0;
        exp_req.push_back(e);
      end
      for (int r = 0; r < int'(d.m); r++) begin
        e.addr = d.a_addr + 32'(r) * d.a_stride;
        e.len = d.k; e.we = 1'b0; e.kind = 1;
        exp_req.push_back(e);
      end
      if (d.store) begin
        for (int w = 0; w < 2; w++) begin
          e.addr = st_base(st_issue) + 32'(w) * 32'h20;
          e.len = 5'(st_issue + 1); e.we = 1'b1; e.kind = 2;
          exp_req.push_back(e);
        end
        st_issue++;
        exp_st++;
      end
    end
    cbuf.push_back(d);
  endtask

  task automatic drive_cfg();
    if (cbuf.size() > 0) begin
      bus.cfg_valid    = 1'b1;
      bus.cfg_mode     = cbuf[0].mode;
      bus.cfg_store    = cbuf[0].store;
      bus.cfg_b_addr   = cbuf[0].b_addr;
      bus.cfg_a_addr   = cbuf[0].a_addr;
      bus.cfg_b_stride = cbuf[0].b_stride;
      bus.cfg_a_stride = cbuf[0].a_stride;
      bus.cfg_msize    = cbuf[0].m;
      bus.cfg_ksize    = cbuf[0].k;
      bus.cfg_nsize    = cbuf[0].n;
    end else begin
      bus.cfg_valid    = 1'b0;
      bus.cfg_mode     = 2'($urandom);
      bus.cfg_store    = 1'($urandom);
      bus.cfg_b_addr   = $urandom;
      bus.cfg_a_addr   = $urandom;
      bus.cfg_b_stride = $urandom;
      bus.cfg_a_stride = $urandom;
      bus.cfg_msize    = 5'($urandom);
      bus.cfg_ksize    = 5'($urandom);
      bus.cfg_nsize    = 5'($urandom);
    end
  endtask

  // config buffer, memory ready and downstream ready drivers
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend) begin
        pop_pend = 1'b0;
        if (cbuf.size() > 0) void'(cbuf.pop_front());
      end
      case (rr_mode)
        0: bus.req_ready = 1'b1;
        1: bus.req_ready = 1'($urandom);
        2: begin
          bus.req_ready = (rr_phase % 3 == 0);
          rr_phase++;
        end
        default: bus.req_ready = 1'b0;
      endcase
      bus.ready_for_hi = (rfh_mode == 0) ? rfh_force : 1'($urandom);
      drive_cfg();
    end
  end

  // store engine model: two writes per tile, then st_done
  initial begin
    int lim;
    bus.st_req_valid = 1'b0;
    bus.st_req_addr  = '0;
    bus.st_req_len   = '0;
    bus.st_req_we    = 1'b0;
    bus.st_done      = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.st_start) begin
        for (int w = 0; w < 2; w++) begin
          @(posedge clk);
          #1;
          bus.st_req_valid = 1'b1;
          bus.st_req_addr  = st_base(st_eng) + 32'(w) * 32'h20;
          bus.st_req_len   = 5'(st_eng + 1);
          bus.st_req_we    = 1'b1;
          lim = 0;
          do begin
            @(negedge clk);
            lim++;
          end while (!bus.req_ready && lim < 200);
          if (lim >= 200) begin
            total++;
            bad++;
            $display("FAIL store_hs: got no req_ready need handshake");
          end
        end
        @(posedge clk);
        #1;
        bus.st_req_valid = 1'b0;
        bus.st_req_we    = 1'b0;
        st_eng++;
        repeat (3) @(posedge clk);
        #1 bus.st_done = 1'b1;
        @(posedge clk);
        #1 bus.st_done = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    req_t e;
    bit ee;
    if (!rst) begin
      if (bus.req_valid && bus.req_ready) begin
        if (exp_req.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexp_req: got addr %0h need none", bus.req_addr);
        end else begin
          e = exp_req.pop_front();
          chk("req_addr", 64'(bus.req_addr), 64'(e.addr));
          chk("req_len", 64'(bus.req_len), 64'(e.len));
          chk("req_we", 64'(bus.req_we), 64'(e.we));
          chk("wfetch", 64'(bus.wfetch), 64'(e.kind == 0));
          chk("if_en", 64'(bus.if_en), 64'(e.kind == 1));
        end
      end else begin
        chk("idle_strobes", 64'({bus.wfetch, bus.if_en}), 64'(0));
      end
      if (prev_stall && bus.req_valid)
        chk("stall_hold", 64'(bus.req_addr), 64'(prev_addr));
      prev_stall = bus.req_valid && !bus.req_ready;
      prev_addr  = bus.req_addr;
      if (bus.cfg_ready) begin
        pop_pend = 1'b1;
        if (exp_err.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexp_pop: got cfg_ready need none");
        end else begin
          ee = exp_err.pop_front();
          chk("cfg_err", 64'(bus.cfg_err), 64'(ee));
          chk("pf_start", 64'(bus.prefetch_start), 64'(!ee));
        end
      end
      n_wf  += int'(bus.wfetch);
      n_if  += int'(bus.if_en);
      n_ps  += int'(bus.prefetch_start);
      n_pd  += int'(bus.prefetch_done);
      n_st  += int'(bus.st_start);
      n_err += int'(bus.cfg_err);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic wait_idle(string nm);
    int lim;
    lim = 0;
    do begin
      @(negedge clk);
      lim++;
    end while (!(cbuf.size() == 0 && exp_req.size() == 0 && !bus.busy)
               && lim < 3000);
    total++;
    if (lim >= 3000) begin
      bad++;
      $display("FAIL %s: got timeout need idle", nm);
    end
  endtask

  task automatic wait_sig(string nm, int which);
    int lim;
    lim = 0;
    do begin
      @(negedge clk);
      lim++;
    end while (!((which == 0 && bus.cfg_ready) ||
                 (which == 1 && !bus.busy) ||
                 (which == 2 && bus.wfetch)) && lim < 500);
    total++;
    if (lim >= 500) begin
      bad++;
      $display("FAIL %s: got timeout need event", nm);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: got stuck need finish");
    $fatal(1, "timeout");
  end

  initial begin
    desc_t d;
    int w0, i0, s0, p0, e0;
    time t0;
    bus.req_ready = 1'b1;
    bus.ready_for_hi = 1'b1;
    drive_cfg();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 64'(bus.req_valid), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_req_addr", 64'(bus.req_addr), 64'(0));
    chk("rst_req_len", 64'(bus.req_len), 64'(0));
    chk("rst_req_we", 64'(bus.req_we), 64'(0));
    chk("rst_strobes", 64'({bus.cfg_ready, bus.cfg_err, bus.st_start,
        bus.prefetch_start, bus.prefetch_done, bus.wfetch, bus.if_en}), 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;

    // basic tile
    d.mode = 2'd0; d.store = 1'b0;
    d.b_addr = 32'h1000; d.b_stride = 32'h40;
    d.a_addr = 32'h2000; d.a_stride = 32'h10;
    d.k = 5'd3; d.m = 5'd2; d.n = 5'd4;
    w0 = n_wf; i0 = n_if;
    @(posedge clk);
    #2;
    push_desc(d);
    drive_cfg();
    wait_sig("basic_pop", 0);
    t0 = $time;
    wait_sig("basic_done", 1);
    chk("basic_cycles", 64'(($time - t0) / 10), 64'(7));
    wait_idle("basic_idle");
    chk("basic_wf", 64'(n_wf - w0), 64'(3));
    chk("basic_if", 64'(n_if - i0), 64'(2));

    // back-pressure
    rr_mode = 2; rr_phase = 0;
    w0 = n_wf; i0 = n_if;
    @(posedge clk);
    #2;
    push_desc(d);
    drive_cfg();
    wait_idle("bp_idle");
    chk("bp_wf", 64'(n_wf - w0), 64'(3));
    chk("bp_if", 64'(n_if - i0), 64'(2));

    // store handoff
    rr_mode = 0;
    s0 = n_st;
    d.store = 1'b1;
    @(posedge clk);
    #2;
    push_desc(d);
    drive_cfg();
    wait_idle("st_idle");
    chk("st_pulses", 64'(n_st - s0), 64'(1));

    // HW mode gating
    d.store = 1'b0; d.mode = 2'd2;
    rfh_mode = 0; rfh_force = 1'b0;
    p0 = n_ps;
    @(posedge clk);
    #2;
    bus.ready_for_hi = 1'b0;
    push_desc(d);
    d.b_addr = 32'h5000; d.a_addr = 32'h6000;
    push_desc(d);
    drive_cfg();
    repeat (16) @(negedge clk);
    chk("hw_wait_ps", 64'(n_ps - p0), 64'(1));
    chk("hw_busy", 64'(bus.busy), 64'(1));
    @(posedge clk);
    #2;
    rfh_force = 1'b1;
    bus.ready_for_hi = 1'b1;
    @(negedge clk);
    chk("hw_release", 64'(bus.prefetch_start), 64'(1));
    wait_idle("hw_idle");

    // illegal descriptor then a valid one
    e0 = n_err;
    d.mode = 2'd0; d.k = 5'd0;
    @(posedge clk);
    #2;
    push_desc(d);
    d.k = 5'd2; d.b_addr = 32'h7000;
    push_desc(d);
    drive_cfg();
    wait_idle("ill_idle");
    chk("ill_err", 64'(n_err - e0), 64'(1));

    // reset mid-prefetch
    d.k = 5'd4; d.b_addr = 32'h9000;
    @(posedge clk);
    #2;
    push_desc(d);
    drive_cfg();
    wait_sig("rst_wf", 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    rr_mode = 3;
    bus.req_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus.req_valid), 64'(0));
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_addr", 64'(bus.req_addr), 64'(0));
    exp_req.delete();
    exp_pd--;
    @(posedge clk);
    #2;
    rst = 1'b0;
    rr_mode = 0;
    d.b_addr = 32'hA000;
    push_desc(d);
    drive_cfg();
    wait_idle("rst_restart");

    // randomized traffic
    rr_mode = 1;
    rfh_mode = 1;
    for (int t = 0; t < 60; t++) begin
      int r;
      d.mode = 2'($urandom);
      d.store = ($urandom % 4 == 0);
      d.b_addr = $urandom; d.a_addr = $urandom;
      d.b_stride = $urandom; d.a_stride = $urandom;
      r = $urandom % 16;
      d.k = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'(1 + $urandom % 5);
      d.m = ($urandom % 12 == 0) ? 5'd0 : 5'(1 + $urandom % 5);
      d.n = 5'($urandom);
      @(posedge clk);
      #2;
      push_desc(d);
      drive_cfg();
      if ($urandom % 4 == 0) wait_idle("rand_idle");
    end
    wait_idle("final_idle");

    chk("tot_pf_start", 64'(n_ps), 64'(exp_ps));
    chk("tot_pf_done", 64'(n_pd), 64'(exp_pd));
    chk("tot_st_start", 64'(n_st), 64'(exp_st));
    chk("left_req", 64'(exp_req.size()), 64'(0));
    chk("left_pop", 64'(exp_err.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
